// File: rtl/mux_scan_n_1_v_pkg.sv
// Shared state encoding and mode constants for the scanning N:1 multiplexer.
package mux_scan_n_1_v_pkg;

    typedef enum logic [1:0] {
        S_MAN   = 2'd0,
        S_DWELL = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_n_1_v_comb.sv
// Combinational N:1 channel select with an out-of-range flag for selects >= N_CH.
module mux_n_1_comb_v #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] i_code,
    input  logic [SEL_W-1:0]  i_sel_code,
    output logic [W-1:0]      o_f,
    output logic              o_oor
);

    // Loop compare keeps every part-select in range when N_CH is not a power of two.
    always_comb begin
        o_f   = '0;
        o_oor = 1'b1;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (i_sel_code == SEL_W'(k)) begin
                o_f   = i_code[k*W +: W];
                o_oor = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_n_1_v.sv
// Registered N:1 multiplexer with valid/ready output, manual select and round-robin auto-scan.
module mux_scan_n_1_v
    import mux_scan_n_1_v_pkg::*;
#(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned W       = 1,
    parameter int unsigned SEL_W   = $clog2(N_CH),
    parameter int unsigned DWELL_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_mode,
    input  logic [SEL_W-1:0]    i_sel_code,
    input  logic [DWELL_W-1:0]  i_dwell,
    input  logic [N_CH*W-1:0]   i_code,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [W-1:0]        o_f,
    output logic [SEL_W-1:0]    o_ch,
    output logic                o_err
);

    state_e               state_q, state_d;
    logic                 mode_q;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [W-1:0]         f_q, f_d;
    logic [SEL_W-1:0]     ch_q, ch_d;
    logic                 err_q, err_d;

    logic                 free;
    logic                 capture;
    logic [SEL_W-1:0]     mux_sel;
    logic [W-1:0]         mux_f;
    logic                 mux_oor;

    assign mux_sel = (state_q == S_HOLD) ? ptr_q : i_sel_code;

    mux_n_1_comb_v #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mux (
        .i_code     (i_code),
        .i_sel_code (mux_sel),
        .o_f        (mux_f),
        .o_oor      (mux_oor)
    );

    assign free = !valid_q || i_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (i_mode != mode_q) begin
            ptr_d   = '0;
            cnt_d   = '0;
            state_d = (i_mode == MODE_SCAN) ? S_DWELL : S_MAN;
        end else if (i_en) begin
            unique case (state_q)
                S_MAN: capture = free;
                // >= lets a lowered dwell release the hold on the next cycle.
                S_DWELL: begin
                    if (cnt_q >= i_dwell) state_d = S_HOLD;
                    else                  cnt_d   = cnt_q + DWELL_W'(1);
                end
                S_HOLD: begin
                    if (free) begin
                        capture = 1'b1;
                        ptr_d   = (ptr_q == SEL_W'(N_CH - 1)) ? '0 : ptr_q + SEL_W'(1);
                        cnt_d   = '0;
                        state_d = S_DWELL;
                    end
                end
                default: state_d = S_MAN;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        f_d     = f_q;
        ch_d    = ch_q;
        err_d   = err_q;
        if (capture) begin
            valid_d = 1'b1;
            f_d     = mux_f;
            ch_d    = mux_sel;
            err_d   = (mode_q == MODE_MAN) && mux_oor;
        end else if (free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= (i_mode == MODE_SCAN) ? S_DWELL : S_MAN;
            mode_q  <= i_mode;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            f_q     <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= i_mode;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            f_q     <= f_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    assign o_valid = valid_q;
    assign o_f     = f_q;
    assign o_ch    = ch_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_mux_scan_n_1_v.sv
// Bench for mux_scan_n_1_v: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux_scan_n_1_v;

    logic       clk;
    logic       rst_n;
    logic       en, mode, ready;
    logic [2:0] sel;
    logic [3:0] dwell;
    logic [7:0] code;
    logic       valid;
    logic [0:0] f;
    logic [2:0] ch;
    logic       err;

    logic       en6, mode6, ready6;
    logic [2:0] sel6;
    logic [3:0] dwell6;
    logic [5:0] code6;
    logic       valid6;
    logic [0:0] f6;
    logic [2:0] ch6;
    logic       err6;

    int n_cmp = 0;
    int n_bad = 0;

    mux_scan_n_1_v #(.N_CH(8), .W(1), .SEL_W(3), .DWELL_W(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
        .i_sel_code(sel), .i_dwell(dwell), .i_code(code), .i_ready(ready),
        .o_valid(valid), .o_f(f), .o_ch(ch), .o_err(err)
    );

    mux_scan_n_1_v #(.N_CH(6), .W(1), .SEL_W(3), .DWELL_W(4)) u_dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en6), .i_mode(mode6),
        .i_sel_code(sel6), .i_dwell(dwell6), .i_code(code6), .i_ready(ready6),
        .o_valid(valid6), .o_f(f6), .o_ch(ch6), .o_err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the 8-channel instance: a pending sample, a round-robin
    // pointer, and a count of dwell cycles served before the pointed channel may be taken.
    logic       m_valid, m_err;
    logic [0:0] m_f;
    logic [2:0] m_ch;
    bit         m_scan, m_ready_to_take, m_cap, m_free;
    int         m_ptr, m_waited, m_chan;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 0; m_f = 0; m_ch = 0; m_err = 0;
            m_ptr = 0; m_waited = 0; m_ready_to_take = 0; m_scan = mode;
        end else begin
            m_free = !m_valid || ready;
            m_cap  = 0;
            if (mode != m_scan) begin
                m_scan = mode; m_ptr = 0; m_waited = 0; m_ready_to_take = 0;
            end else if (en) begin
                if (!m_scan) begin
                    if (m_free) begin m_cap = 1; m_chan = sel; end
                end else if (!m_ready_to_take) begin
                    if (m_waited >= dwell) m_ready_to_take = 1;
                    else m_waited++;
                end else if (m_free) begin
                    m_cap = 1; m_chan = m_ptr;
                    m_ptr = (m_ptr + 1) % 8; m_waited = 0; m_ready_to_take = 0;
                end
            end
            if (m_cap) begin
                m_valid = 1;
                m_ch    = 3'(m_chan);
                m_f     = (m_chan < 8) ? code[m_chan] : 1'b0;
                m_err   = !m_scan && (m_chan >= 8);
            end else if (m_free) begin
                m_valid = 0;
            end
        end
    end

    task automatic test_reset;
        rst_n = 0; en = 0; mode = 0; ready = 1; sel = 0; dwell = 0; code = 8'hFF;
        en6 = 0; mode6 = 0; ready6 = 1; sel6 = 0; dwell6 = 0; code6 = '1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({valid, f, ch, err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset8 got v=%b f=%b ch=%0d e=%b exp all zero", valid, f, ch, err);
        end
        n_cmp++;
        if ({valid6, f6, ch6, err6} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset6 got v=%b f=%b ch=%0d e=%b exp all zero", valid6, f6, ch6, err6);
        end
        rst_n = 1;
    endtask

    task automatic test_manual_sweep;
        bit exp_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        mode = 0; en = 1; ready = 1; code = 8'b1010_0101;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b1 || f[0] !== exp_seq[s] || ch !== 3'(s) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL manual_sweep sel=%0d got v=%b f=%b ch=%0d e=%b exp v=1 f=%0d ch=%0d e=0",
                         s, valid, f, ch, err, exp_seq[s], s);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [0:0] ef;
        en6 = 1; ready6 = 1; mode6 = 0; code6 = 6'b000100;
        sel6 = 3'd7;
        @(negedge clk);
        n_cmp++;
        if (valid6 !== 1'b1 || f6 !== 1'b0 || err6 !== 1'b1 || ch6 !== 3'd7) begin
            n_bad++;
            $display("FAIL oor_sel7 got v=%b f=%b ch=%0d e=%b exp v=1 f=0 ch=7 e=1", valid6, f6, ch6, err6);
        end
        sel6 = 3'd2;
        @(negedge clk);
        n_cmp++;
        if (valid6 !== 1'b1 || f6 !== 1'b1 || err6 !== 1'b0 || ch6 !== 3'd2) begin
            n_bad++;
            $display("FAIL oor_sel2 got v=%b f=%b ch=%0d e=%b exp v=1 f=1 ch=2 e=0", valid6, f6, ch6, err6);
        end
        for (int i = 0; i < 12; i++) begin
            sel6  = 3'($urandom);
            code6 = 6'($urandom);
            ef    = (sel6 < 6) ? code6[sel6] : 1'b0;
            @(negedge clk);
            n_cmp++;
            if (f6 !== ef || err6 !== (sel6 >= 6) || ch6 !== sel6) begin
                n_bad++;
                $display("FAIL oor_rand sel=%0d got f=%b ch=%0d e=%b exp f=%b e=%b",
                         sel6, f6, ch6, err6, ef, sel6 >= 6);
            end
        end
        en6 = 0;
    endtask

    task automatic test_scan_wrap;
        logic [2:0] exp_ch;
        bit         exp_v;
        @(negedge clk);
        rst_n = 0; mode = 1; dwell = 2; ready = 1; en = 1;
        @(negedge clk);
        rst_n = 1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            code = 8'($urandom);
            @(negedge clk);
            exp_v = (cyc % 4 == 0);
            n_cmp++;
            if (valid !== exp_v) begin
                n_bad++;
                $display("FAIL scan_wrap_valid cyc=%0d got %b exp %b", cyc, valid, exp_v);
            end
            if (exp_v) begin
                exp_ch = 3'(((cyc / 4) - 1) % 8);
                n_cmp++;
                if (ch !== exp_ch || {f, err} !== {m_f, 1'b0}) begin
                    n_bad++;
                    $display("FAIL scan_wrap_ch cyc=%0d got ch=%0d f=%b e=%b exp ch=%0d f=%b e=0",
                             cyc, ch, f, err, exp_ch, m_f);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        logic [0:0] f_h;
        logic [2:0] ch_h;
        bit         seen = 0;
        dwell = 1; ready = 1; en = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL bp_wait got no valid in 20 cycles exp a sample");
        end
        f_h = f; ch_h = ch;
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            code = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b1 || f !== f_h || ch !== ch_h) begin
                n_bad++;
                $display("FAIL bp_stall i=%0d got v=%b f=%b ch=%0d exp v=1 f=%b ch=%0d",
                         i, valid, f, ch, f_h, ch_h);
            end
        end
        ready = 1;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || ch !== ch_h + 3'd1) begin
            n_bad++;
            $display("FAIL bp_release got v=%b ch=%0d exp v=1 ch=%0d", valid, ch, ch_h + 3'd1);
        end
    endtask

    task automatic test_mode_switch_enable;
        int k = 0;
        int g = 0;
        mode = 0; en = 1; ready = 1;
        for (int i = 0; i < 3; i++) begin
            sel = 3'($urandom); code = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({valid, f, ch, err} !== {m_valid, m_f, m_ch, m_err}) begin
                n_bad++;
                $display("FAIL mode_man got v=%b f=%b ch=%0d e=%b exp v=%b f=%b ch=%0d e=%b",
                         valid, f, ch, err, m_valid, m_f, m_ch, m_err);
            end
        end
        mode = 1; dwell = 2;
        do begin
            @(negedge clk);
            k++;
        end while (!valid && k < 12);
        n_cmp++;
        if (k != 5 || ch !== 3'd0) begin
            n_bad++;
            $display("FAIL mode_switch got first sample after %0d cycles ch=%0d exp 5 cycles ch=0", k, ch);
        end
        do begin
            @(negedge clk);
            g++;
            if (g == 1) en = 0;
            if (g == 4) en = 1;
        end while (!valid && g < 20);
        n_cmp++;
        if (g != 7 || ch !== 3'd1) begin
            n_bad++;
            $display("FAIL enable_gap got gap=%0d ch=%0d exp gap=7 ch=1", g, ch);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({valid, f, ch, err} !== {m_valid, m_f, m_ch, m_err}) begin
                n_bad++;
                $display("FAIL random i=%0d got v=%b f=%b ch=%0d e=%b exp v=%b f=%b ch=%0d e=%b",
                         i, valid, f, ch, err, m_valid, m_f, m_ch, m_err);
            end
            code  = 8'($urandom);
            sel   = 3'($urandom);
            ready = ($urandom % 4) != 0;
            en    = ($urandom % 8) != 0;
            rst_n = ($urandom % 150) != 0;
            if ($urandom % 40 == 0) mode = ~mode;
            if ($urandom % 16 == 0) dwell = 4'($urandom_range(0, 3));
        end
        rst_n = 1;
    endtask

    task automatic test_reset_mid_stall;
        bit seen = 0;
        mode = 1; dwell = 0; en = 1; ready = 0; code = 8'hFF;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        n_cmp++;
        if (!seen || f !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_wait got v=%b f=%b exp v=1 f=1", valid, f);
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_cmp++;
        if ({valid, f, ch, err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_mid_stall got v=%b f=%b ch=%0d e=%b exp all zero", valid, f, ch, err);
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_manual_sweep();
        test_out_of_range();
        test_scan_wrap();
        test_back_pressure();
        test_mode_switch_enable();
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
